// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_pkg
// Brief  : Shared constants for the pipelined CPU front end.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          ADDR_W       = 32;
  localparam int          PC_INC       = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/pipe_reg.sv
//------------------------------------------------------------------------------
// Module : pipe_reg
// Brief  : W-bit pipeline register; async reset and sync clear to RST_VAL,
//          clear has priority over enable.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : pipe_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module : fetch_stage
// Brief  : IF stage - PC register, next-PC mux and IF/ID pipeline register.
//          Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = ADDR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VECTOR),
  parameter int              CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_target_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [PC_W-1:0]  imem_instr_i,
  output logic [PC_W-1:0]  id_pc4_o,
  output logic [PC_W-1:0]  id_instr_o,
  output logic             id_valid_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_pc_next;
  logic            w_squash;
  logic            w_load;

  assign w_pc_plus4 = r_pc + PC_W'(PC_INC);
  assign w_squash   = flush_i | branch_taken_i;
  assign w_load     = ~w_squash & ~stall_i;

  // A taken branch overrides a stall so the redirect is never lost.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (branch_taken_i) begin
      w_pc_next = {branch_target_i[PC_W-1:2], 2'b00};
    end else if (stall_i) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign imem_addr_o = r_pc;

  pipe_reg #(.W(PC_W), .RST_VAL('0)) u_id_pc4 (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(~stall_i), .i_clr(w_squash),
    .i_d(w_pc_plus4), .o_q(id_pc4_o)
  );

  pipe_reg #(.W(PC_W), .RST_VAL(PC_W'(NOP_INSTR))) u_id_instr (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(~stall_i), .i_clr(w_squash),
    .i_d(imem_instr_i), .o_q(id_instr_o)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_id_valid (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(~stall_i), .i_clr(w_squash),
    .i_d(1'b1), .o_q(id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_load && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
      if (stall_i && !w_squash && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_squash && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_stage
// Brief  : Self-checking bench for fetch_stage against a behavioural model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall, flush, br;
  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  addr, instr, pc4, id_instr;
  logic             valid;
  logic [CNT_W-1:0] fcnt, scnt, xcnt;

  logic [PC_W-1:0]  addr2, instr2, pc4_2, id_instr2;
  logic             valid2;
  logic [CNT_W-1:0] fcnt2, scnt2, xcnt2;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference state
  logic [31:0] m_pc, m_pc4, m_instr, m_fcnt, m_scnt, m_xcnt;
  logic        m_valid;
  logic [31:0] m2_pc, m2_pc4;

  always #5 clk = ~clk;

  // Instruction memory image: each word encodes its own address.
  assign instr  = addr  | 32'hA000_0000;
  assign instr2 = addr2 | 32'hA000_0000;

  fetch_stage #(.PC_W(PC_W), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .branch_taken_i(br), .branch_target_i(tgt), .imem_addr_o(addr),
    .imem_instr_i(instr), .id_pc4_o(pc4), .id_instr_o(id_instr),
    .id_valid_o(valid), .fetch_cnt_o(fcnt), .stall_cnt_o(scnt),
    .flush_cnt_o(xcnt)
  );

  fetch_stage #(.PC_W(PC_W), .RESET_PC(32'hFFFF_FFF8), .CNT_W(CNT_W)) u_dut_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .flush_i(1'b0),
    .branch_taken_i(1'b0), .branch_target_i(32'h0), .imem_addr_o(addr2),
    .imem_instr_i(instr2), .id_pc4_o(pc4_2), .id_instr_o(id_instr2),
    .id_valid_o(valid2), .fetch_cnt_o(fcnt2), .stall_cnt_o(scnt2),
    .flush_cnt_o(xcnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_fcnt = 0; m_scnt = 0; m_xcnt = 0;
    m2_pc = 32'hFFFF_FFF8; m2_pc4 = 32'h0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock of the reference: priorities taken straight from the rules.
  task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] t);
    logic squash;
    squash = f | b;
    if (squash) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = m_pc | 32'hA000_0000; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
    if (!squash && !s) m_fcnt = sat_inc(m_fcnt);
    if (s && !squash)  m_scnt = sat_inc(m_scnt);
    if (squash)        m_xcnt = sat_inc(m_xcnt);
`endif
    if (b)       m_pc = t & 32'hFFFF_FFFC;
    else if (!s) m_pc = m_pc + 32'd4;
    m2_pc4 = m2_pc + 32'd4;
    m2_pc  = m2_pc + 32'd4;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  addr,     m_pc);
    chk({tag, ".pc4"},   pc4,      m_pc4);
    chk({tag, ".instr"}, id_instr, m_instr);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    chk({tag, ".fcnt"},  fcnt,     m_fcnt);
    chk({tag, ".scnt"},  scnt,     m_scnt);
    chk({tag, ".xcnt"},  xcnt,     m_xcnt);
    chk({tag, ".addr2"}, addr2,    m2_pc);
    chk({tag, ".pc4_2"}, pc4_2,    m2_pc4);
  endtask

  // Entered and left on a falling edge.
  task automatic cycle(input string tag, input logic s, input logic f, input logic b,
                       input logic [31:0] t);
    stall = s; flush = f; br = b; tgt = t;
    @(posedge clk);
    model_step(s, f, b, t);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; tgt = 32'h0;
    model_reset();
    #22;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from reset
    for (int i = 0; i < 4; i++) cycle("seq", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq.pc_at_0x10", addr, 32'h10);

    // Three-cycle stall
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle("seq2", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("br.pc_at_0x20", addr, 32'h20);

    // Branch redirect with unaligned target, then one bubble
    cycle("br", 1'b0, 1'b0, 1'b1, 32'h0000_0043);
    chk("br.bubble", {31'd0, valid}, 32'd0);
    cycle("br_post", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("br.target_pc4", pc4, 32'h44);

    // Stall and branch together, stall and flush together
    cycle("stall_br", 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    chk("stall_br.pc", addr, 32'h100);
    cycle("seq3", 1'b0, 1'b0, 1'b0, 32'h0);
    cycle("stall_flush", 1'b1, 1'b1, 1'b0, 32'h0);
    cycle("flush", 1'b0, 1'b1, 1'b0, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic s, f, b;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 7) == 0);
      cycle("rand", s, f, b, $urandom);
    end

    // Branch near the top of the address space to exercise wrap
    cycle("wrap_br", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
    for (int i = 0; i < 3; i++) cycle("wrap", 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a stall, between edges
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst", 1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_stage

`default_nettype wire
